cute_fetch_ctrl: RTL and testbench

Instruction fetch and issue sequencer sitting in front of the `cufsm` control unit. It fetches 9-bit instruction words from program memory over a request/acknowledge handshake, fetches the extra immediate word for MVI, and presents the instruction on `ir` with `run` held high. It then waits for the control unit's `done`, applies taken jumps to the program counter, and guards every instruction with a completion watchdog.

---
 rtl/cute_fetch_ctrl_if.sv | 30 +++
 rtl/cute_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_cute_fetch_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cute_fetch_ctrl_if.sv
// rtl/cute_fetch_ctrl_if.sv - fetch/issue sequencer bus: program memory, control unit and status signals
interface cute_fetch_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              go;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [8:0]        mem_rdata;
    logic [8:0]        ir;
    logic              run;
    logic [8:0]        imm;
    logic              imm_valid;
    logic              done;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_target;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fault;

    modport master (
        input  go, mem_ack, mem_rdata, done, jmp, jmp_target,
        output mem_req, mem_addr, ir, run, imm, imm_valid, pc, busy, fault
    );

    modport slave (
        output go, mem_ack, mem_rdata, done, jmp, jmp_target,
        input  mem_req, mem_addr, ir, run, imm, imm_valid, pc, busy, fault
    );
endinterface

// File: rtl/cute_fetch_ctrl.sv
// rtl/cute_fetch_ctrl.sv - instruction fetch/issue sequencer with MVI immediate fetch, jumps and completion watchdog
module cute_fetch_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  Resetn,
    cute_fetch_ctrl_if.master     bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FETCH_IMM,
        S_EXEC,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [8:0]        ir_q, ir_d;
    logic [8:0]        imm_q, imm_d;
    logic              imm_valid_q, imm_valid_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    // Next-state, PC sequencing and watchdog; every register holds unless its event occurs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        imm_valid_d = imm_valid_q;
        wd_d        = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.mem_ack) begin
                    ir_d = bus.mem_rdata;
                    pc_d = pc_q + ADDR_W'(1);
                    wd_d = '0;
                    // MVI carries its immediate in the following program word
                    if (bus.mem_rdata[8:6] == 3'b011) begin
                        state_d = S_FETCH_IMM;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_FETCH_IMM: begin
                if (bus.mem_ack) begin
                    imm_d       = bus.mem_rdata;
                    imm_valid_d = 1'b1;
                    pc_d        = pc_q + ADDR_W'(1);
                    wd_d        = '0;
                    state_d     = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.done) begin
                    if (bus.jmp) begin
                        pc_d = bus.jmp_target;
                    end
                    imm_valid_d = 1'b0;
                    wd_d        = '0;
                    state_d     = bus.go ? S_FETCH : S_IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // Last permitted cycle passed without done: lock up until reset
                    state_d = S_FAULT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            imm_q       <= '0;
            imm_valid_q <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imm_q       <= imm_d;
            imm_valid_q <= imm_valid_d;
            wd_q        <= wd_d;
        end
    end

    // Outputs decode from registered state only, so no input reaches an output in the same cycle
    assign bus.mem_req   = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
    assign bus.mem_addr  = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.imm       = imm_q;
    assign bus.imm_valid = imm_valid_q;
    assign bus.run       = (state_q == S_EXEC);
    assign bus.busy      = (state_q == S_FETCH) || (state_q == S_FETCH_IMM) || (state_q == S_EXEC);
    assign bus.fault     = (state_q == S_FAULT);
endmodule

// File: tb/tb_cute_fetch_ctrl.sv
// tb/tb_cute_fetch_ctrl.sv - randomized bench for cute_fetch_ctrl with a behavioural reference model
module tb_cute_fetch_ctrl;
    localparam int AW = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic Resetn;

    always #5 clk = ~clk;

    cute_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    cute_fetch_ctrl #(
        .ADDR_W   (AW),
        .RESET_PC (8'h00),
        .TIMEOUT  (TO)
    ) dut (
        .clk    (clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] mem [256];

    logic       p_go    = 1'b0;
    logic       p_rstn  = 1'b0;
    bit         p_stray = 1'b0;
    int         p_jmode = 0;
    logic [7:0] p_tgt   = 8'h00;
    int         p_wlo = 0, p_whi = 0, p_llo = 1, p_lhi = 1;
    int         ack_wait = 0, lat = 1, env_wait = 0, env_exec = 0;

    typedef enum {M_IDLE, M_FETCH, M_IMM, M_EXEC, M_FAULT} mph_t;
    mph_t       m_ph;
    logic [7:0] m_pc;
    logic [8:0] m_ir, m_imm;
    logic       m_immv;
    int         m_entry;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph    = M_IDLE;
        m_pc    = 8'h00;
        m_ir    = 9'h000;
        m_imm   = 9'h000;
        m_immv  = 1'b0;
        m_entry = 0;
    endtask

    task automatic model_step(input logic rstn, input logic go, input logic ack, input logic [8:0] rd,
                              input logic dn, input logic jp, input logic [7:0] tgt);
        if (!rstn) begin
            model_reset();
            return;
        end
        case (m_ph)
            M_IDLE: if (go) m_ph = M_FETCH;
            M_FETCH: if (ack) begin
                m_ir = rd;
                m_pc = m_pc + 8'd1;
                if (rd[8:6] == 3'b011) m_ph = M_IMM;
                else begin
                    m_ph    = M_EXEC;
                    m_entry = cyc + 1;
                end
            end
            M_IMM: if (ack) begin
                m_imm   = rd;
                m_immv  = 1'b1;
                m_pc    = m_pc + 8'd1;
                m_ph    = M_EXEC;
                m_entry = cyc + 1;
            end
            M_EXEC: if (dn) begin
                if (jp) m_pc = tgt;
                m_immv = 1'b0;
                m_ph   = go ? M_FETCH : M_IDLE;
            end else if (cyc + 1 - m_entry >= TO) begin
                m_ph = M_FAULT;
            end
            default: ;
        endcase
    endtask

    task automatic compare();
        chk("mem_req",   bus.mem_req,   (m_ph == M_FETCH) || (m_ph == M_IMM));
        chk("mem_addr",  bus.mem_addr,  m_pc);
        chk("pc",        bus.pc,        m_pc);
        chk("run",       bus.run,       m_ph == M_EXEC);
        chk("busy",      bus.busy,      (m_ph == M_FETCH) || (m_ph == M_IMM) || (m_ph == M_EXEC));
        chk("fault",     bus.fault,     m_ph == M_FAULT);
        chk("ir",        bus.ir,        m_ir);
        chk("imm",       bus.imm,       m_imm);
        chk("imm_valid", bus.imm_valid, m_immv);
    endtask

    task automatic cycle();
        logic       ack, dn, jp;
        logic [8:0] rd;
        logic [7:0] tgt;
        @(negedge clk);
        cyc++;
        compare();
        ack = 1'b0;
        rd  = 9'($urandom);
        if (bus.mem_req === 1'b1) begin
            if (env_wait >= ack_wait) begin
                ack      = 1'b1;
                rd       = mem[bus.mem_addr];
                env_wait = 0;
                ack_wait = $urandom_range(p_whi, p_wlo);
            end else begin
                env_wait++;
            end
        end else begin
            env_wait = 0;
            ack = p_stray && ($urandom_range(0, 3) == 0);
        end
        dn  = 1'b0;
        jp  = 1'b0;
        tgt = 8'($urandom);
        if (bus.run === 1'b1) begin
            if (env_exec >= lat) begin
                dn       = 1'b1;
                env_exec = 0;
                lat      = $urandom_range(p_lhi, p_llo);
                if (p_jmode == 1) begin
                    jp  = 1'b1;
                    tgt = p_tgt;
                end else if (p_jmode == 2) begin
                    jp = ($urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 3) == 0) tgt = 8'hF8 | 8'($urandom_range(0, 7));
                end
            end else begin
                env_exec++;
                jp = p_stray && ($urandom_range(0, 1) == 1);
            end
        end else begin
            env_exec = 0;
            if (p_stray) begin
                dn = ($urandom_range(0, 3) == 0);
                jp = ($urandom_range(0, 1) == 1);
            end
        end
        Resetn         = p_rstn;
        bus.go         = p_go;
        bus.mem_ack    = ack;
        bus.mem_rdata  = rd;
        bus.done       = dn;
        bus.jmp        = jp;
        bus.jmp_target = tgt;
        model_step(p_rstn, p_go, ack, rd, dn, jp, tgt);
    endtask

    task automatic set_wait(input int lo, input int hi);
        p_wlo = lo; p_whi = hi; ack_wait = $urandom_range(hi, lo);
    endtask

    task automatic set_lat(input int lo, input int hi);
        p_llo = lo; p_lhi = hi; lat = $urandom_range(hi, lo);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 60) begin cycle(); n++; end
        chk(nm, bus.mem_req, 1'b1);
    endtask

    task automatic wait_addr(input string nm, input logic [7:0] a);
        int n = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === a) && n < 60) begin cycle(); n++; end
        chk(nm, bus.mem_addr, a);
    endtask

    task automatic wait_run(input string nm);
        int n = 0;
        while (bus.run !== 1'b1 && n < 60) begin cycle(); n++; end
        chk(nm, bus.run, 1'b1);
    endtask

    task automatic wait_norun(input string nm);
        int n = 0;
        while (bus.run !== 1'b0 && n < 60) begin cycle(); n++; end
        chk(nm, bus.run, 1'b0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 256; i++) mem[i] = 9'o001;
        mem[0]     = 9'o012;
        mem[1]     = 9'o123;
        mem[2]     = 9'o123;
        mem[3]     = 9'o123;
        mem[4]     = 9'o312;
        mem[5]     = 9'h0A5;
        mem[6]     = 9'o045;
        mem[7]     = 9'o250;
        mem[8]     = 9'o013;
        mem[8'h20] = 9'o250;
        mem[8'hFF] = 9'o014;

        Resetn = 1'b0; bus.go = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 9'h000;
        bus.done = 1'b0; bus.jmp = 1'b0; bus.jmp_target = 8'h00;
        model_reset();
        cycle();
        cycle();
        chk("rst_pc", bus.pc, 8'h00);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ir", bus.ir, 9'h000);

        // simple MV, zero-wait memory, done one cycle after run
        p_rstn = 1'b1; p_go = 1'b1; set_wait(0, 0); set_lat(1, 1);
        wait_req("t1_req");
        chk("t1_addr", bus.mem_addr, 8'h00);
        wait_run("t1_run");
        chk("t1_ir", bus.ir, 9'o012);
        wait_req("t1_next");
        chk("t1_next_addr", bus.mem_addr, 8'h01);
        chk("t1_pc", bus.pc, 8'h01);
        chk("t1_fault", bus.fault, 1'b0);

        // MVI at 4 with immediate at 5
        wait_addr("mvi_fetch", 8'h04);
        wait_addr("mvi_imm_fetch", 8'h05);
        chk("mvi_no_run", bus.run, 1'b0);
        wait_run("mvi_run");
        chk("mvi_ir", bus.ir, 9'o312);
        chk("mvi_imm", bus.imm, 9'h0A5);
        chk("mvi_imm_valid", bus.imm_valid, 1'b1);
        wait_req("mvi_next");
        chk("mvi_next_addr", bus.mem_addr, 8'h06);
        chk("mvi_imm_clr", bus.imm_valid, 1'b0);

        // jump taken at 7, then back to 7 and not taken
        wait_addr("jmp_fetch7", 8'h07);
        wait_run("jmp_run7");
        p_jmode = 1; p_tgt = 8'h20;
        wait_req("jmp_req");
        chk("jmp_addr", bus.mem_addr, 8'h20);
        p_tgt = 8'h07;
        wait_run("jmp_run20");
        wait_addr("jmp_back7", 8'h07);
        p_jmode = 0;
        wait_run("nojmp_run7");
        wait_req("nojmp_req");
        chk("nojmp_addr", bus.mem_addr, 8'h08);

        // PC wrap at 0xFF with three wait states
        set_wait(3, 3);
        p_jmode = 1; p_tgt = 8'hFF;
        wait_run("wrap_run8");
        wait_addr("wrap_fetch", 8'hFF);
        p_jmode = 0;
        set_lat(14, 14);
        cnt = 1;
        cycle();
        while (bus.mem_req === 1'b1 && bus.mem_addr === 8'hFF && cnt < 10) begin cnt++; cycle(); end
        chk("wrap_hold_cycles", cnt, 4);
        chk("wrap_pc", bus.pc, 8'h00);

        // done on the last allowed cycle, then watchdog expiry
        wait_req("wd_edge_done");
        chk("wd_edge_fault", bus.fault, 1'b0);
        chk("wd_edge_addr", bus.mem_addr, 8'h00);
        set_lat(100, 100);
        wait_run("wd_run");
        cnt = 0;
        while (bus.fault !== 1'b1 && cnt < 40) begin cycle(); cnt++; end
        chk("wd_cycles", cnt, TO);
        chk("wd_run_low", bus.run, 1'b0);
        chk("wd_req_low", bus.mem_req, 1'b0);
        for (int i = 0; i < 6; i++) begin
            p_go = i[0];
            cycle();
            chk("fault_sticky", bus.fault, 1'b1);
        end
        chk("fault_busy", bus.busy, 1'b0);
        p_rstn = 1'b0; cycle();
        p_rstn = 1'b1; p_go = 1'b0; cycle();
        chk("fault_cleared", bus.fault, 1'b0);
        chk("fault_rst_pc", bus.pc, 8'h00);

        // go dropped during EXEC
        set_wait(0, 2); set_lat(3, 3); p_go = 1'b1;
        wait_run("stop_run");
        p_go = 1'b0;
        wait_norun("stop_done");
        chk("stop_req", bus.mem_req, 1'b0);
        chk("stop_busy", bus.busy, 1'b0);
        cycle();
        chk("stop_idle", bus.busy, 1'b0);

        // reset during a pending fetch, then stray acks and dones
        set_wait(6, 6); p_go = 1'b1;
        wait_req("rstf_req");
        cycle();
        p_rstn = 1'b0; cycle();
        p_rstn = 1'b1; p_go = 1'b0; p_stray = 1'b1; cycle();
        chk("rstf_req_low", bus.mem_req, 1'b0);
        chk("rstf_pc", bus.pc, 8'h00);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rstf_stray_busy", bus.busy, 1'b0);
            chk("rstf_stray_ir", bus.ir, 9'h000);
        end

        // randomized program and environment
        for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
        set_wait(0, 3); set_lat(0, 16); p_jmode = 2; p_go = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0) p_go = ~p_go;
            p_rstn = !((bus.fault === 1'b1 && $urandom_range(0, 7) == 0) || $urandom_range(0, 399) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
